// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding instruction-memory read, registered hand-off to decode, flush support.
// Optional IF_MISALIGN_TRAP_EN: misaligned PCs raise out_fault instead of being fetched.
module instruction_fetch #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        kill, kill_nxt;
  logic [31:0] req_pc, req_pc_nxt;
  logic [31:0] instr_nxt, opc_nxt;
  logic        fault_q, fault_nxt;
  logic        misaligned;

`ifdef IF_MISALIGN_TRAP_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign imem_addr = {pc[31:2], 2'b00};
  assign out_valid = (state == HOLD);
  assign out_fault = fault_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    state_nxt  = state;
    kill_nxt   = kill;
    req_pc_nxt = req_pc;
    instr_nxt  = out_instr;
    opc_nxt    = out_pc;
    fault_nxt  = fault_q;
    imem_req   = 1'b0;
    pc_en      = 1'b0;

    case (state)
      FETCH: begin
        if (misaligned) begin
          // Trap path: no memory access, present a faulting NOP at the offending PC.
          if (!flush) begin
            state_nxt = HOLD;
            instr_nxt = RESET_INSTR;
            opc_nxt   = pc;
            fault_nxt = 1'b1;
          end
        end else begin
          imem_req = !rst;
          if (imem_req && imem_gnt) begin
            state_nxt  = WAIT;
            req_pc_nxt = pc;
            kill_nxt   = flush;
          end
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          kill_nxt = 1'b0;
          if (kill || flush) begin
            state_nxt = FETCH;
          end else begin
            state_nxt = HOLD;
            instr_nxt = imem_rdata;
            opc_nxt   = req_pc;
            fault_nxt = 1'b0;
          end
        end else if (flush) begin
          // The read cannot be cancelled; remember to drop its data when it lands.
          kill_nxt = 1'b1;
        end
      end

      HOLD: begin
        if (flush) begin
          state_nxt = FETCH;
          instr_nxt = RESET_INSTR;
          fault_nxt = 1'b0;
        end else if (out_ready) begin
          pc_en     = 1'b1;
          state_nxt = FETCH;
        end
      end

      default: state_nxt = FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      kill      <= 1'b0;
      req_pc    <= '0;
      out_instr <= RESET_INSTR;
      out_pc    <= '0;
      fault_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      kill      <= kill_nxt;
      req_pc    <= req_pc_nxt;
      out_instr <= instr_nxt;
      out_pc    <= opc_nxt;
      fault_q   <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic, checked by a queue scoreboard.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  instruction_fetch #(.RESET_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_t;

  fetch_t      exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem [logic [31:0]];

  // Stimulus knobs, applied at the start of each cycle by step().
  int          gnt_prob;
  int          lat_fixed;
  bit          ready_rand, junk_en, flush_next, redirect_valid;
  logic        ready_val, rst_next;
  logic [31:0] redirect_pc;

  // Shared between the monitor (negedge) and the memory / PC models (posedge).
  bit          pc_en_seen, gnt_seen, resp_pending, live;
  int          resp_wait;
  logic [31:0] gnt_data, resp_data;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (mem.exists(addr)) return mem[addr];
    return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One cycle of input drive: PC model, memory responder, handshake inputs.
  task automatic step();
    @(posedge clk);
    #1;
    rst = rst_next;
    if (pc_en_seen) pc = pc + 32'd4;
    pc_en_seen = 1'b0;
    if (redirect_valid) begin
      pc = redirect_pc;
      redirect_valid = 1'b0;
    end
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    if (gnt_seen) begin
      resp_pending = 1'b1;
      resp_data    = gnt_data;
      resp_wait    = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 2));
      gnt_seen     = 1'b0;
    end
    if (resp_pending) begin
      if (resp_wait == 0) begin
        imem_rvalid  = 1'b1;
        imem_rdata   = resp_data;
        resp_pending = 1'b0;
        live         = 1'b0;
      end else begin
        resp_wait--;
      end
    end else if (junk_en && $urandom_range(0, 3) == 0) begin
      imem_rvalid = 1'b1;
    end
    imem_gnt   = ($urandom_range(0, 99) < gnt_prob);
    out_ready  = ready_rand ? ($urandom_range(0, 9) < 6) : ready_val;
    flush      = flush_next;
    flush_next = 1'b0;
  endtask

  task automatic cyc();
    step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cyc);
    int n = 0;
    while (!out_valid && n < max_cyc) begin
      cyc();
      n++;
    end
    check_bit("wait_valid_timeout", out_valid, 1'b1);
  endtask

  // Monitor / scoreboard.
  logic        prev_hold;
  logic [31:0] prev_instr, prev_pc;
  fetch_t      exp_e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      live       = 1'b0;
      prev_hold  = 1'b0;
      gnt_seen   = 1'b0;
      pc_en_seen = 1'b0;
    end else begin
      if (prev_hold) begin
        check_bit("hold_valid", out_valid, 1'b1);
        check("hold_instr", out_instr, prev_instr);
        check("hold_pc", out_pc, prev_pc);
      end
      if (imem_req) begin
        check("imem_addr", imem_addr, {pc[31:2], 2'b00});
        check_bit("single_outstanding", live, 1'b0);
      end
      if (flush) begin
        check_bit("flush_pc_en", pc_en, 1'b0);
        exp_q.delete();
      end else if (out_valid && out_ready) begin
        check_bit("handoff_pc_en", pc_en, 1'b1);
        if (exp_q.size() == 0) begin
          check_bit("unexpected_output", out_valid, 1'b0);
        end else begin
          exp_e = exp_q.pop_front();
          check("out_instr", out_instr, exp_e.instr);
          check("out_pc", out_pc, exp_e.pc);
          check_bit("out_fault", out_fault, exp_e.fault);
        end
      end else begin
        check_bit("idle_pc_en", pc_en, 1'b0);
      end
      pc_en_seen = pc_en;
      if (imem_req && imem_gnt) begin
        gnt_seen = 1'b1;
        gnt_data = mem_word(imem_addr);
        live     = 1'b1;
        if (!flush) exp_q.push_back('{instr: mem_word(imem_addr), pc: pc, fault: 1'b0});
      end
      prev_hold  = out_valid && !out_ready && !flush;
      prev_instr = out_instr;
      prev_pc    = out_pc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rst_next = 1'b1;
    pc = 32'h100; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    flush = 1'b0; out_ready = 1'b0;
    gnt_prob = 100; lat_fixed = 0; ready_rand = 1'b0; ready_val = 1'b1;
    junk_en = 1'b0; flush_next = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    pc_en_seen = 1'b0; gnt_seen = 1'b0; resp_pending = 1'b0; live = 1'b0; resp_wait = 0;
    gnt_data = '0; resp_data = '0; prev_hold = 1'b0; prev_instr = '0; prev_pc = '0;
    mem[32'h100] = 32'h0050_0093;
    mem[32'h200] = 32'hDEAD_BEEF;

    #2;
    check_bit("rst_imem_req", imem_req, 1'b0);
    check_bit("rst_pc_en", pc_en, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_out_fault", out_fault, 1'b0);
    check("rst_out_instr", out_instr, NOP);
    check("rst_out_pc", out_pc, 32'h0);

    // Basic fetch at 0x100, zero-wait memory, decode always ready.
    rst_next = 1'b0;
    cyc();
    check_bit("basic_req", imem_req, 1'b1);
    check("basic_addr", imem_addr, 32'h100);
    cyc();
    check_bit("basic_wait_req", imem_req, 1'b0);
    check_bit("basic_wait_valid", out_valid, 1'b0);
    cyc();
    check_bit("basic_valid", out_valid, 1'b1);
    check("basic_instr", out_instr, 32'h0050_0093);
    check("basic_pc", out_pc, 32'h100);
    check_bit("basic_pc_en", pc_en, 1'b1);
    cyc();
    check_bit("basic_next_valid", out_valid, 1'b0);
    check_bit("basic_next_req", imem_req, 1'b1);
    check("basic_next_addr", imem_addr, 32'h104);

    // Backpressure: decode stalls five cycles, then takes one instruction.
    ready_val = 1'b0;
    cyc();
    cyc();
    check_bit("bp_valid", out_valid, 1'b1);
    check("bp_pc", out_pc, 32'h104);
    check("bp_instr", out_instr, mem_word(32'h104));
    check_bit("bp_pc_en", pc_en, 1'b0);
    repeat (4) begin
      cyc();
      check_bit("bp_stall_valid", out_valid, 1'b1);
      check_bit("bp_stall_pc_en", pc_en, 1'b0);
      check_bit("bp_stall_req", imem_req, 1'b0);
    end
    ready_val = 1'b1;
    cyc();
    check_bit("bp_release_pc_en", pc_en, 1'b1);
    gnt_prob = 0;
    cyc();
    check_bit("bp_after_pc_en", pc_en, 1'b0);
    check_bit("bp_after_valid", out_valid, 1'b0);
    check("bp_after_addr", imem_addr, 32'h108);

    // Flush one cycle after the grant; the late data must be dropped.
    redirect_pc = 32'h200; redirect_valid = 1'b1;
    cyc();
    gnt_prob = 100; lat_fixed = 2;
    cyc();
    check_bit("fw_req", imem_req, 1'b1);
    check("fw_addr", imem_addr, 32'h200);
    flush_next = 1'b1;
    cyc();
    check_bit("fw_flush_req", imem_req, 1'b0);
    cyc();
    check_bit("fw_wait_valid", out_valid, 1'b0);
    cyc();
    check_bit("fw_rvalid_valid", out_valid, 1'b0);
    check_bit("fw_rvalid_req", imem_req, 1'b0);
    gnt_prob = 0;
    cyc();
    check_bit("fw_after_valid", out_valid, 1'b0);
    check_bit("fw_after_req", imem_req, 1'b1);
    check("fw_after_addr", imem_addr, 32'h200);

    // Flush in HOLD while decode is ready: no hand-off, NOP restored.
    gnt_prob = 100; lat_fixed = 0; ready_val = 1'b0;
    cyc();
    cyc();
    cyc();
    check_bit("fh_valid", out_valid, 1'b1);
    check("fh_instr", out_instr, 32'hDEAD_BEEF);
    flush_next = 1'b1; ready_val = 1'b1; gnt_prob = 0;
    cyc();
    check_bit("fh_flush_pc_en", pc_en, 1'b0);
    cyc();
    check_bit("fh_after_valid", out_valid, 1'b0);
    check("fh_after_instr", out_instr, NOP);
    check_bit("fh_after_pc_en", pc_en, 1'b0);
    check("fh_after_addr", imem_addr, 32'h200);

    // Reset while a read is outstanding; the late response must be ignored.
    gnt_prob = 100; lat_fixed = 3;
    cyc();
    check_bit("rw_req", imem_req, 1'b1);
    gnt_prob = 0;
    cyc();
    check_bit("rw_wait_req", imem_req, 1'b0);
    rst_next = 1'b1; redirect_pc = 32'h0; redirect_valid = 1'b1;
    cyc();
    check_bit("rw_rst_req", imem_req, 1'b0);
    check_bit("rw_rst_valid", out_valid, 1'b0);
    check("rw_rst_instr", out_instr, NOP);
    check("rw_rst_pc", out_pc, 32'h0);
    rst_next = 1'b0;
    cyc();
    check_bit("rw_rel_req", imem_req, 1'b1);
    check("rw_rel_addr", imem_addr, 32'h0);
    cyc();
    check_bit("rw_late_valid", out_valid, 1'b0);
    cyc();
    check_bit("rw_after_valid", out_valid, 1'b0);
    check_bit("rw_after_req", imem_req, 1'b1);
    check("rw_after_addr", imem_addr, 32'h0);
    gnt_prob = 100; lat_fixed = 0; ready_val = 1'b1;
    wait_valid(10);
    check("rw_refetch_pc", out_pc, 32'h0);
    check("rw_refetch_instr", out_instr, mem_word(32'h0));

    // Misaligned PC 0x102.
    gnt_prob = 0; ready_val = 1'b0;
    redirect_pc = 32'h102; redirect_valid = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
    exp_q.push_back('{instr: NOP, pc: 32'h102, fault: 1'b1});
    cyc();
    check_bit("mis_req", imem_req, 1'b0);
    cyc();
    check_bit("mis_valid", out_valid, 1'b1);
    check_bit("mis_fault", out_fault, 1'b1);
    check("mis_pc", out_pc, 32'h102);
    check("mis_instr", out_instr, NOP);
    ready_val = 1'b1;
    redirect_pc = 32'h1000; redirect_valid = 1'b1;
    cyc();
    check_bit("mis_pc_en", pc_en, 1'b1);
`else
    cyc();
    check_bit("mis_req", imem_req, 1'b1);
    check("mis_addr", imem_addr, 32'h100);
    gnt_prob = 100; ready_val = 1'b1;
    wait_valid(10);
    check("mis_pc", out_pc, 32'h102);
    check_bit("mis_fault", out_fault, 1'b0);
    check("mis_instr", out_instr, 32'h0050_0093);
    redirect_pc = 32'h1000; redirect_valid = 1'b1;
`endif

    // Randomized traffic: grant stalls, variable latency, stray rvalid, backpressure, flushes.
    gnt_prob = 70; lat_fixed = -1; ready_rand = 1'b1; junk_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 14) == 0) begin
        flush_next = 1'b1;
        redirect_valid = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
        redirect_pc = $urandom() & 32'hFFFF_FFFC;
`else
        redirect_pc = $urandom();
`endif
      end
      cyc();
    end

    gnt_prob = 0; ready_rand = 1'b0; ready_val = 1'b1;
    repeat (10) cyc();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly downstream of the program counter. Takes the current PC and issues a single-outstanding read to instruction memory over a req/gnt + rvalid handshake. Registers the returned instruction with its PC and presents it to decode over a valid/ready handshake. Pulses `pc_en` to advance the PC once per accepted instruction, and supports a flush that discards in-flight or held instructions.

## Interface
- `RESET_INSTR`, default `32'h0000_0013`: value of `out_instr` after reset and after a flush (NOP).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc`  in  32  current PC from the program counter.
- `pc_en`  out  1  one-cycle advance strobe to the program counter.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  read address: `{pc[31:2], 2'b00}`.
- `imem_gnt`  in  1  memory accepts the request in a cycle where `imem_req && imem_gnt`.
- `imem_rvalid`  in  1  read data valid; arrives at least 1 cycle after the grant.
- `imem_rdata`  in  32  instruction word; sampled only when `imem_rvalid` is high.
- `flush`  in  1  discard the current fetch; takes priority over every other event.
- `out_valid`  out  1  instruction held for decode.
- `out_ready`  in  1  decode accepts; handoff occurs when `out_valid && out_ready`.
- `out_instr`  out  32  fetched instruction.
- `out_pc`  out  32  address of `out_instr`.
- `out_fault`  out  1  misaligned-PC fault flag, qualified by `out_valid`.

## Operation
- **FSM states:** FETCH, WAIT, HOLD. Reset state is FETCH.
- **Reset values:** `imem_req=0`, `pc_en=0`, `out_valid=0`, `out_fault=0`, `out_instr=RESET_INSTR`, `out_pc=0`, `kill=0`. `imem_req` is 0 while `rst` is high.
- **FETCH:**
  - `imem_req=1` and `imem_addr` are driven combinationally from `pc`.
  - On grant: capture `pc` into `req_pc` and go to WAIT.
  - No grant: stay in FETCH.
- **WAIT:**
  - `imem_req=0`.
  - On `imem_rvalid` with `kill=0`: load `out_instr<=imem_rdata`, `out_pc<=req_pc`, `out_fault<=0`, then go to HOLD.
  - On `imem_rvalid` with `kill=1`: drop the data, clear `kill`, go to FETCH.
- **HOLD:**
  - `out_valid=1`.
  - On handoff: `pc_en=1` for that cycle, go to FETCH.
  - Otherwise hold all outputs stable (no change while `out_ready=0`).
- **Flush, priority over grant, rvalid and handoff:**
  - In FETCH with grant in the same cycle: go to WAIT with `kill=1`.
  - In FETCH without grant: stay in FETCH.
  - In WAIT without rvalid: set `kill=1`.
  - In WAIT with rvalid: drop the data, go to FETCH.
  - In HOLD: clear `out_valid`, restore `out_instr=RESET_INSTR`, go to FETCH, no `pc_en`.
- **Redirection:** flush never asserts `pc_en`; PC redirection is owned by the branch logic.
- **Outstanding reads:** at most one. A response is never accepted outside WAIT; `imem_rvalid` in FETCH or HOLD is ignored.

## Timing
- Grant in cycle N → `imem_rvalid` no earlier than N+1 → `out_valid` rises at N+2 (for rvalid at N+1).
- Handoff at cycle H → `pc_en` high during H → PC updates at H+1 edge → next `imem_req` at H+1.
- Peak throughput: one instruction per 3 cycles with zero-wait memory and `out_ready` tied high.
- Reset asserted mid-operation: outputs return to reset values immediately. Any response arriving after reset deassertion is ignored, because FETCH does not accept rvalid.
- `out_valid` never drops without a handoff, flush or reset.

## Configuration
- Macro: `IF_MISALIGN_TRAP_EN`.
- **Defined:**
  - In FETCH, if `pc[1:0]!=0`, no request is issued (`imem_req=0`).
  - Next cycle: HOLD with `out_fault=1`, `out_instr=RESET_INSTR`, `out_pc=pc`.
  - The fault is consumed by decode through the normal handoff, and `pc_en` pulses.
- **Undefined:**
  - `pc[1:0]` is ignored and the fetch proceeds at `{pc[31:2],2'b00}`.
  - `out_pc` still reports the full `pc`.
  - `out_fault` is tied 0 (port retained).

## Test plan
- **Basic fetch:** `pc=0x100`, gnt immediate, rvalid 1 cycle later with `0x00500093`, `out_ready=1` → `out_instr=0x00500093`, `out_pc=0x100`; `pc_en` pulses once; next request at the new pc.
- **Backpressure:** `out_ready=0` for 5 cycles → outputs stable, no `pc_en`, no `imem_req`; raise ready → single handoff, single `pc_en`.
- **Flush during WAIT:** grant at `pc=0x200`, flush 1 cycle later, rvalid after 3 cycles with `0xDEADBEEF` → never presented; next request issued the cycle after rvalid.
- **Flush in HOLD with simultaneous `out_ready=1`:** no handoff, no `pc_en`, `out_valid=0`, `out_instr=0x00000013`.
- **Reset mid-WAIT:** then release; late rvalid arrives → ignored, FETCH re-requests `pc=0`.
- **Misaligned `pc=0x102`:** with `IF_MISALIGN_TRAP_EN` → no `imem_req`, `out_fault=1`, `out_pc=0x102`. Without it → `imem_addr=0x100`, `out_fault=0`.
